// File: rtl/ccg_pkg.sv
// Shared types and the lane function for the CCG XOR-of-AND fanout pipeline.
package ccg_pkg;

  typedef enum logic [1:0] {
    CCG_XOR  = 2'd0,
    CCG_XNOR = 2'd1,
    CCG_AND  = 2'd2,
    CCG_BUF  = 2'd3
  } ccg_mode_e;

  localparam int LANE_IN_W = 4;

  function automatic logic ccg_eval(input ccg_mode_e mode, input logic a,
                                    input logic b, input logic c);
    logic f;
    f = 1'b0;
    case (mode)
      CCG_XOR:  f = a ^ (b & c);
      CCG_XNOR: f = ~(a ^ (b & c));
      CCG_AND:  f = b & c;
      CCG_BUF:  f = a;
      default:  f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ccg_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus {p,f} for every lane.
module ccg_pipe_stage
  import ccg_pkg::*;
#(
  parameter int CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld,
  input  logic            vld_in,
  input  logic [2*CH-1:0] dat_in,
  output logic            vld,
  output logic [2*CH-1:0] dat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (ld) begin
      vld <= vld_in;
    end
  end

  // Data carries no reset; consumers qualify it with the valid bit.
  always_ff @(posedge clk) begin
    if (ld) begin
      dat <= dat_in;
    end
  end

endmodule

// File: rtl/ccg_xfn_fanout_pipe.sv
// CH-lane XOR-of-AND evaluator with a DEPTH-stage elastic pipeline, output fanout
// and a saturating delivered-result counter.
module ccg_xfn_fanout_pipe
  import ccg_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DEPTH = 2,
  parameter int FAN_F = 7,
  parameter int FAN_P = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_IN_W*CH-1:0]   in_x,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FAN_F*CH-1:0]       out_f,
  output logic [FAN_P*CH-1:0]       out_p,
  output logic [CNT_W-1:0]          out_cnt
);

  localparam int SW = 2 * CH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  logic [SW-1:0]    eval_p0;
  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] ld_p;
  logic [SW-1:0]    dat_p [DEPTH];
  logic [SW-1:0]    last_p;
  logic             out_hs;

  // Stage 0 input: evaluate every lane, packing {p,f} per lane.
  always_comb begin
    eval_p0 = '0;
    for (int i = 0; i < CH; i++) begin
      eval_p0[2*i]   = ccg_eval(ccg_mode_e'(in_mode),
                                in_x[LANE_IN_W*i],
                                in_x[LANE_IN_W*i+1],
                                in_x[LANE_IN_W*i+2]);
      eval_p0[2*i+1] = in_x[LANE_IN_W*i+3];
    end
  end

  // A stage loads when any stage from it to the tail is empty or the tail drains;
  // written flat so there is no combinational chain through ld_p itself.
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      assign ld_p[k] = out_ready | ~(&vld_p[DEPTH-1:k]);
      if (k == 0) begin : g_head
        ccg_pipe_stage #(.CH(CH)) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .ld     (ld_p[k]),
          .vld_in (in_valid),
          .dat_in (eval_p0),
          .vld    (vld_p[k]),
          .dat    (dat_p[k])
        );
      end else begin : g_body
        ccg_pipe_stage #(.CH(CH)) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .ld     (ld_p[k]),
          .vld_in (vld_p[k-1]),
          .dat_in (dat_p[k-1]),
          .vld    (vld_p[k]),
          .dat    (dat_p[k])
        );
      end
    end
  endgenerate

  assign in_ready  = ld_p[0];
  assign out_valid = vld_p[DEPTH-1];
  assign out_hs    = out_valid & out_ready;

  // Output stage: qualify the tail data with its valid, then replicate per lane.
  assign last_p = dat_p[DEPTH-1] & {SW{vld_p[DEPTH-1]}};

  genvar i, j;
  generate
    for (i = 0; i < CH; i++) begin : g_lane
      for (j = 0; j < FAN_F; j++) begin : g_fan_f
        assign out_f[i*FAN_F+j] = last_p[2*i];
      end
      for (j = 0; j < FAN_P; j++) begin : g_fan_p
        assign out_p[i*FAN_P+j] = last_p[2*i+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_hs) begin
      out_cnt <= sat_inc(out_cnt);
    end
  end

endmodule

// File: tb/tb_ccg_xfn_fanout_pipe.sv
// Directed and randomised checks of ccg_xfn_fanout_pipe against a behavioural lane model.
module tb_ccg_xfn_fanout_pipe;

  localparam int CH    = 4;
  localparam int DEPTH = 2;
  localparam int FAN_F = 7;
  localparam int FAN_P = 4;
  localparam int CNT_W = 16;
  localparam int FW    = FAN_F * CH;
  localparam int PW    = FAN_P * CH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [4*CH-1:0] in_x = '0;
  logic [1:0]      in_mode = '0;
  logic            in_ready, out_valid;
  logic [FW-1:0]   out_f;
  logic [PW-1:0]   out_p;
  logic [CNT_W-1:0] out_cnt;
  logic            s_in_ready, s_out_valid;
  logic [FW-1:0]   s_out_f;
  logic [PW-1:0]   s_out_p;
  logic [3:0]      s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [FW-1:0] f;
    logic [PW-1:0] p;
  } exp_t;

  exp_t sb[$];

  logic [15:0] vec [10] = '{16'h8F31, 16'h0000, 16'hFFFF, 16'h1248,
                            16'h7777, 16'hA5C3, 16'h0F0F, 16'h6E29,
                            16'hB4D1, 16'h3C96};

  always #5 clk = ~clk;

  ccg_xfn_fanout_pipe #(
    .CH(CH), .DEPTH(DEPTH), .FAN_F(FAN_F), .FAN_P(FAN_P), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_p(out_p), .out_cnt(out_cnt)
  );

  ccg_xfn_fanout_pipe #(
    .CH(CH), .DEPTH(DEPTH), .FAN_F(FAN_F), .FAN_P(FAN_P), .CNT_W(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_x(in_x), .in_mode(in_mode), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_f(s_out_f), .out_p(s_out_p), .out_cnt(s_cnt)
  );

  function automatic exp_t model(input logic [1:0] m, input logic [4*CH-1:0] x);
    exp_t e;
    logic a, b, c, p, f;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      a = x[4*i];
      b = x[4*i+1];
      c = x[4*i+2];
      p = x[4*i+3];
      case (m)
        2'd0:    f = a ^ (b & c);
        2'd1:    f = ~(a ^ (b & c));
        2'd2:    f = b & c;
        default: f = a;
      endcase
      for (int j = 0; j < FAN_F; j++) e.f[i*FAN_F+j] = f;
      for (int j = 0; j < FAN_P; j++) e.p[i*FAN_P+j] = p;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    n_chk++;
    if (out_valid !== 1'b0 || out_f !== '0 || out_p !== '0 || out_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b f=%h p=%h cnt=%0d, expected all zero",
               out_valid, out_f, out_p, out_cnt);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_x = 16'h8F31;
    in_mode = 2'd0;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency1: out_valid got %b expected 0", out_valid);
    end
    step();
    n_chk++;
    if (out_valid !== 1'b1 || out_f !== 28'h0003FFF || out_p !== 16'hFF00) begin
      n_fail++;
      $display("FAIL single_out: got valid=%b f=%h p=%h expected 1 0003fff ff00",
               out_valid, out_f, out_p);
    end
    step();
    n_chk++;
    if (out_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cnt: got cnt=%0d valid=%b expected 1 0", out_cnt, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, first, last;
    exp_t e;
    sent = 0; got = 0; first = -1; last = -1;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      in_valid = (sent < 10);
      in_x = vec[sent % 10];
      in_mode = 2'(sent % 4);
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got f=%h, expected no beat", out_f);
        end else begin
          e = sb.pop_front();
          if (out_f !== e.f || out_p !== e.p) begin
            n_fail++;
            $display("FAIL b2b_data: got f=%h p=%h expected f=%h p=%h", out_f, out_p, e.f, e.p);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_mode, in_x));
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (got != 10 || last - first != 9 || out_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL b2b_summary: got %0d beats over %0d cycles cnt=%0d, expected 10 over 10 cnt=10",
               got, last - first + 1, out_cnt);
    end
  endtask

  task automatic test_stall();
    int acc, got, bad;
    logic [FW-1:0] hold_f;
    exp_t e;
    acc = 0; got = 0; bad = 0;
    do_reset();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1;
      in_x = vec[acc];
      in_mode = 2'(acc % 4);
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(model(in_mode, in_x));
        acc++;
      end
      step();
    end
    in_x = vec[acc];
    in_mode = 2'(acc % 4);
    #1;
    n_chk++;
    if (acc != DEPTH || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_fill: accepted %0d in_ready=%b valid=%b, expected %0d 0 1",
               acc, in_ready, out_valid, DEPTH);
    end
    hold_f = out_f;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      if (out_f !== hold_f || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      in_valid = (acc < 5);
      in_x = vec[acc % 10];
      in_mode = 2'(acc % 4);
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stall_extra: got f=%h, expected no beat", out_f);
        end else begin
          e = sb.pop_front();
          if (out_f !== e.f || out_p !== e.p) begin
            n_fail++;
            $display("FAIL stall_data: got f=%h p=%h expected f=%h p=%h", out_f, out_p, e.f, e.p);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_mode, in_x));
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (got != 5 || acc != 5) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d out %0d in, expected 5 5", got, acc);
    end
  endtask

  task automatic test_random();
    int acc, got, hs, bad_hold;
    logic prev_hold;
    logic [FW-1:0] prev_f;
    exp_t e;
    acc = 0; got = 0; hs = 0; bad_hold = 0;
    prev_hold = 1'b0;
    prev_f = '0;
    do_reset();
    for (int cyc = 0; cyc < 10000 && (acc < 1000 || sb.size() > 0); cyc++) begin
      if (prev_hold && (out_valid !== 1'b1 || out_f !== prev_f)) bad_hold++;
      in_valid = (acc < 1000) && ($urandom_range(1) == 1);
      in_x = 16'($urandom);
      in_mode = 2'($urandom_range(3));
      out_ready = ($urandom_range(1) == 1);
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got f=%h, expected no beat", out_f);
        end else begin
          e = sb.pop_front();
          if (out_f !== e.f || out_p !== e.p) begin
            n_fail++;
            $display("FAIL rand_data: beat %0d got f=%h p=%h expected f=%h p=%h",
                     got, out_f, out_p, e.f, e.p);
          end
        end
        got++;
        hs++;
      end
      prev_hold = out_valid && !out_ready;
      prev_f = out_f;
      if (in_valid && in_ready) begin
        sb.push_back(model(in_mode, in_x));
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_chk++;
    if (acc != 1000 || got != 1000 || sb.size() != 0 || bad_hold != 0) begin
      n_fail++;
      $display("FAIL rand_summary: in=%0d out=%0d left=%0d hold_err=%0d, expected 1000 1000 0 0",
               acc, got, sb.size(), bad_hold);
    end
    n_chk++;
    if (out_cnt !== 16'(hs)) begin
      n_fail++;
      $display("FAIL rand_cnt: got %0d expected %0d", out_cnt, hs);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_x = 16'h0001;
    in_mode = 2'd0;
    step();
    in_valid = 1'b0;
    step();
    step();
    n_chk++;
    if (out_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_pre_cnt: got %0d expected 1", out_cnt);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 16'hFFFF;
    in_mode = 2'd1;
    step();
    in_x = 16'h5555;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_cnt !== '0 || out_f !== '0 || out_p !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got valid=%b cnt=%0d f=%h p=%h expected 0 0 0 0",
               out_valid, out_cnt, out_f, out_p);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0 || out_cnt !== '0) begin
      n_fail++;
      $display("FAIL midrst_dropped: %0d ghost cycles cnt=%0d, expected 0 0", seen, out_cnt);
    end
  endtask

  task automatic test_saturate();
    int sent, hs;
    logic [3:0] at15;
    sent = 0; hs = 0; at15 = '0;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid = (sent < 20);
      in_x = vec[sent % 10];
      in_mode = 2'(sent % 4);
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) hs++;
      step();
      if (hs == 15) at15 = s_cnt;
    end
    in_valid = 1'b0;
    n_chk++;
    if (at15 !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_reach: got %0d expected 15", at15);
    end
    n_chk++;
    if (s_cnt !== 4'd15 || out_cnt !== 16'd20 || hs != 20) begin
      n_fail++;
      $display("FAIL sat_hold: narrow cnt=%0d wide cnt=%0d hs=%0d, expected 15 20 20",
               s_cnt, out_cnt, hs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
